// File: rtl/dac_spi_arbiter.sv
// Round-robin arbiter for two 10-bit sample sources driving an MCP4912 dual DAC:
// each grant becomes one 16-bit SPI frame, a CS-high gap and an LDAC strobe.
module dac_spi_arbiter #(
  parameter int unsigned HALF_DIV  = 2,
  parameter int unsigned LD_CYCLES = 2,
  parameter bit          BUF       = 1'b0,
  parameter bit          GA_N      = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       REQ_A,
  input  logic [9:0] DATA_A,
  output logic       ACK_A,
  input  logic       REQ_B,
  input  logic [9:0] DATA_B,
  output logic       ACK_B,
  output logic       BUSY,
  output logic       DAC_CS,
  output logic       DAC_SCK,
  output logic       DAC_SDI,
  output logic       DAC_LD
);

  localparam int unsigned      DIV_W    = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int unsigned      LD_W     = (LD_CYCLES > 1) ? $clog2(LD_CYCLES) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(LD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CSHI,
    ST_LOAD
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_q, bit_d;
  logic [LD_W-1:0]  ld_cnt_q, ld_cnt_d;
  logic [15:0]      sh_q, sh_d;
  logic             last_b_q, last_b_d;
  logic             ack_a_q, ack_a_d;
  logic             ack_b_q, ack_b_d;
  logic             busy_q, busy_d;
  logic             cs_n_q, cs_n_d;
  logic             sck_q, sck_d;
  logic             ld_n_q, ld_n_d;
  logic             grant_b;

  // B wins only when A is absent, or when both ask and A was served last.
  assign grant_b = REQ_B & (~REQ_A | ~last_b_q);

  always_comb begin
    // NOTE: every next-state value is defaulted first so no branch can infer a latch.
    state_d  = state_q;
    div_d    = div_q;
    bit_d    = bit_q;
    ld_cnt_d = ld_cnt_q;
    sh_d     = sh_q;
    last_b_d = last_b_q;
    ack_a_d  = 1'b0;
    ack_b_d  = 1'b0;
    busy_d   = busy_q;
    cs_n_d   = cs_n_q;
    sck_d    = sck_q;
    ld_n_d   = ld_n_q;

    unique case (state_q)
      ST_IDLE: begin
        if (REQ_A | REQ_B) begin
          state_d  = ST_SHIFT;
          last_b_d = grant_b;
          ack_a_d  = ~grant_b;
          ack_b_d  = grant_b;
          busy_d   = 1'b1;
          cs_n_d   = 1'b0;
          sck_d    = 1'b0;
          div_d    = '0;
          bit_d    = '0;
          sh_d     = {grant_b, BUF, GA_N, 1'b1, (grant_b ? DATA_B : DATA_A), 2'b00};
        end
      end

      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sck_q) begin
            sck_d = 1'b1;
          end else begin
            // End of a high phase: the next bit is presented while SCK is low.
            sck_d = 1'b0;
            if (bit_q == 4'd15) begin
              state_d = ST_CSHI;
              cs_n_d  = 1'b1;
            end else begin
              bit_d = bit_q + 4'd1;
              sh_d  = {sh_q[14:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end

      ST_CSHI: begin
        state_d  = ST_LOAD;
        ld_n_d   = 1'b0;
        ld_cnt_d = '0;
      end

      ST_LOAD: begin
        if (ld_cnt_q == LD_LAST) begin
          state_d = ST_IDLE;
          ld_n_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          ld_cnt_d = ld_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: non-blocking assignments only, so every register samples pre-edge values.
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      div_q    <= '0;
      bit_q    <= '0;
      ld_cnt_q <= '0;
      // NOTE: the shift register is reset as well because its MSB drives DAC_SDI directly.
      sh_q     <= '0;
      last_b_q <= 1'b1;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      busy_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      ld_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      ld_cnt_q <= ld_cnt_d;
      sh_q     <= sh_d;
      last_b_q <= last_b_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      busy_q   <= busy_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      ld_n_q   <= ld_n_d;
    end
  end

  assign ACK_A   = ack_a_q;
  assign ACK_B   = ack_b_q;
  assign BUSY    = busy_q;
  assign DAC_CS  = cs_n_q;
  assign DAC_SCK = sck_q;
  assign DAC_SDI = sh_q[15];
  assign DAC_LD  = ld_n_q;

endmodule

// File: tb/tb_dac_spi_arbiter.sv
// Bench for dac_spi_arbiter: two instances (HALF_DIV=2 and HALF_DIV=1) share stimulus;
// a frame-timing model checks every pin every cycle, plus directed literal checks.
module tb_dac_spi_arbiter;

  localparam int HD0    = 2;
  localparam int HD1    = 1;
  localparam int LDC    = 2;
  localparam bit BUF_P  = 1'b0;
  localparam bit GA_N_P = 1'b1;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       rst_n, req_a, req_b;
  logic [9:0] data_a, data_b;
  logic [1:0] ack_a, ack_b, busy, cs, sck, sdi, ld;

  dac_spi_arbiter #(.HALF_DIV(HD0), .LD_CYCLES(LDC), .BUF(BUF_P), .GA_N(GA_N_P)) u_dut0 (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .REQ_A(req_a), .DATA_A(data_a), .ACK_A(ack_a[0]),
    .REQ_B(req_b), .DATA_B(data_b), .ACK_B(ack_b[0]),
    .BUSY(busy[0]), .DAC_CS(cs[0]), .DAC_SCK(sck[0]), .DAC_SDI(sdi[0]), .DAC_LD(ld[0])
  );

  dac_spi_arbiter #(.HALF_DIV(HD1), .LD_CYCLES(LDC), .BUF(BUF_P), .GA_N(GA_N_P)) u_dut1 (
    .CLOCK_50(clk), .RESET_N(rst_n),
    .REQ_A(req_a), .DATA_A(data_a), .ACK_A(ack_a[1]),
    .REQ_B(req_b), .DATA_B(data_b), .ACK_B(ack_b[1]),
    .BUSY(busy[1]), .DAC_CS(cs[1]), .DAC_SCK(sck[1]), .DAC_SDI(sdi[1]), .DAC_LD(ld[1])
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs as seen by the DUTs at the most recent rising edge.
  logic       rst_s, reqa_s, reqb_s;
  logic [9:0] da_s, db_s;
  always @(posedge clk) begin
    rst_s  <= rst_n;
    reqa_s <= req_a;
    reqb_s <= req_b;
    da_s   <= data_a;
    db_s   <= data_b;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame model: a frame is a start cycle plus a 16-bit word; pin values follow
  // from the offset into the frame.
  bit          m_active [2];
  int          m_start  [2];
  bit          m_last_b [2];
  logic [15:0] m_word   [2];

  initial begin : compare
    int         hd, f, o, k;
    bit         gb, chk_sdi;
    logic [5:0] e_vec;
    logic       e_sdi;
    for (int d = 0; d < 2; d++) begin
      m_active[d] = 1'b0;
      m_start[d]  = 0;
      m_last_b[d] = 1'b1;
      m_word[d]   = '0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        hd = (d == 0) ? HD0 : HD1;
        f  = 32 * hd + 1 + LDC;
        if (rst_s !== 1'b1) begin
          m_active[d] = 1'b0;
          m_last_b[d] = 1'b1;
        end else if ((!m_active[d] || (cyc - 1 - m_start[d]) >= f) && (reqa_s || reqb_s)) begin
          gb          = reqb_s && (!reqa_s || !m_last_b[d]);
          m_last_b[d] = gb;
          m_active[d] = 1'b1;
          m_start[d]  = cyc;
          m_word[d]   = {gb, BUF_P, GA_N_P, 1'b1, (gb ? db_s : da_s), 2'b00};
        end
        // e_vec = {ACK_A, ACK_B, BUSY, DAC_CS, DAC_SCK, DAC_LD}
        e_vec   = 6'b000101;
        e_sdi   = 1'b0;
        chk_sdi = (rst_s !== 1'b1);
        if (rst_s === 1'b1 && m_active[d] && (cyc - m_start[d]) < f) begin
          o        = cyc - m_start[d];
          e_vec[3] = 1'b1;
          if (o == 0) begin
            e_vec[5] = ~m_word[d][15];
            e_vec[4] = m_word[d][15];
          end
          if (o < 32 * hd) begin
            k        = o / (2 * hd);
            e_vec[2] = 1'b0;
            e_vec[1] = ((o % (2 * hd)) >= hd);
            e_sdi    = m_word[d][15 - k];
            chk_sdi  = 1'b1;
          end else if (o > 32 * hd) begin
            e_vec[0] = 1'b0;
          end
        end
        check($sformatf("dut%0d_pins", d),
              {26'd0, ack_a[d], ack_b[d], busy[d], cs[d], sck[d], ld[d]}, {26'd0, e_vec});
        if (chk_sdi) check($sformatf("dut%0d_sdi", d), {31'd0, sdi[d]}, {31'd0, e_sdi});
      end
    end
  end

  task automatic wait_any(input int d, input int budget, output int who, output int at,
                          output int csl);
    who = -1;
    at  = -1;
    csl = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cs[d] === 1'b0) csl++;
      if (ack_a[d] === 1'b1 || ack_b[d] === 1'b1) begin
        who = (ack_b[d] === 1'b1) ? 1 : 0;
        at  = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout dut%0d: no ACK within %0d cycles", d, budget);
    end
  endtask

  // Called in the ACK cycle; shifts in SDI on each SCK rise of the frame.
  task automatic capture_word(input int d, input int hd, output logic [15:0] w);
    logic prev;
    w    = '0;
    prev = sck[d];
    for (int i = 0; i < 32 * hd; i++) begin
      @(negedge clk);
      if (sck[d] === 1'b1 && prev !== 1'b1) w = {w[14:0], sdi[d]};
      prev = sck[d];
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int          who, ta, at, prev_at, csl, o, nrise, cs_last, ld_lo, ld_first, busy_fall, nack, nb;
    logic [15:0] w;
    logic        prev_sck;

    // Reset held with REQ_A asserted
    rst_n  = 1'b0;
    req_a  = 1'b1;
    req_b  = 1'b0;
    data_a = 10'h2AB;
    data_b = 10'h000;
    repeat (3) begin
      @(negedge clk);
      check("reset_pins", {26'd0, cs[0], sck[0], sdi[0], ld[0], ack_a[0], busy[0]}, 32'b100100);
    end

    // Single request A = 0x2AB
    rst_n = 1'b1;
    wait_any(0, 10, who, ta, csl);
    check("single_who", who, 0);
    check("single_cs_sck_at_ack", {30'd0, cs[0], sck[0]}, 32'd0);
    check("model_word_2AB", {16'd0, m_word[0]}, 32'h3AAC);
    req_a     = 1'b0;
    w         = '0;
    nrise     = 0;
    prev_sck  = sck[0];
    cs_last   = -1;
    ld_lo     = 0;
    ld_first  = -1;
    busy_fall = -1;
    nack      = 1;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      o = cyc - ta;
      if (sck[0] === 1'b1 && prev_sck !== 1'b1) begin
        w = {w[14:0], sdi[0]};
        nrise++;
      end
      prev_sck = sck[0];
      if (cs[0] === 1'b0) cs_last = o;
      if (ld[0] === 1'b0) begin
        ld_lo++;
        if (ld_first < 0) ld_first = o;
      end
      if (busy[0] === 1'b0 && busy_fall < 0) busy_fall = o;
      if (ack_a[0] === 1'b1) nack++;
    end
    check("single_frame", {16'd0, w}, 32'h3AAC);
    check("single_sck_rises", nrise, 16);
    check("single_cs_last_low", cs_last, 63);
    check("single_ld_first", ld_first, 65);
    check("single_ld_len", ld_lo, 2);
    check("single_busy_fall", busy_fall, 67);
    check("single_ack_count", nack, 1);

    // Simultaneous requests straight out of reset
    rst_n = 1'b0;
    @(negedge clk);
    data_a = 10'h000;
    data_b = 10'h3FF;
    req_a  = 1'b1;
    req_b  = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_any(0, 10, who, ta, csl);
    check("sim_first_A", who, 0);
    req_a = 1'b0;
    capture_word(0, HD0, w);
    check("sim_frame_A", {16'd0, w}, 32'h3000);
    wait_any(0, 20, who, at, csl);
    check("sim_second_B", who, 1);
    check("sim_ack_spacing", at - ta, 68);
    req_b = 1'b0;
    capture_word(0, HD0, w);
    check("sim_frame_B", {16'd0, w}, 32'hBFFC);
    repeat (10) @(negedge clk);

    // Continuous contention: strict alternation, 68 cycles apart
    rst_n = 1'b0;
    @(negedge clk);
    data_a = 10'h155;
    data_b = 10'h0AA;
    req_a  = 1'b1;
    req_b  = 1'b1;
    rst_n  = 1'b1;
    prev_at = 0;
    for (int i = 0; i < 8; i++) begin
      wait_any(0, 100, who, at, csl);
      check($sformatf("rr_grant%0d", i), who, i % 2);
      if (i > 0) check($sformatf("rr_spacing%0d", i), at - prev_at, 68);
      prev_at = at;
    end

    // Reset in the middle of an A frame; A must still win afterwards
    wait_any(0, 100, who, ta, csl);
    check("midrst_frame_is_A", who, 0);
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_pins", {28'd0, cs[0], sck[0], ld[0], busy[0]}, 32'b1010);
    rst_n = 1'b1;
    ld_lo = 0;
    who   = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ld[0] === 1'b0) ld_lo++;
      if (ack_a[0] === 1'b1 || ack_b[0] === 1'b1) begin
        who = (ack_b[0] === 1'b1) ? 1 : 0;
        break;
      end
    end
    check("midrst_no_ld", ld_lo, 0);
    check("midrst_first_A", who, 0);
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (80) @(negedge clk);

    // Withdrawn B request during a frame
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    data_a = 10'h123;
    data_b = 10'h321;
    req_a  = 1'b1;
    wait_any(0, 10, who, ta, csl);
    check("wd_first_A", who, 0);
    req_a = 1'b0;
    repeat (10) @(negedge clk);
    req_b = 1'b1;
    @(negedge clk);
    req_b = 1'b0;
    nb = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (ack_b[0] === 1'b1) nb++;
      if (ack_b[1] === 1'b1) nb++;
    end
    check("wd_no_ack_b", nb, 0);

    // HALF_DIV=1 instance: 32 CS-low cycles per frame, 36-cycle period
    req_a = 1'b1;
    req_b = 1'b1;
    wait_any(1, 50, who, ta, csl);
    wait_any(1, 50, nb, at, csl);
    check("hd1_period", at - ta, 36);
    check("hd1_cs_low_cycles", csl, 32);
    check("hd1_alternates", {31'd0, (nb != who)}, 32'd1);
    req_a = 1'b0;
    req_b = 1'b0;
    repeat (160) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
